// File: rtl/multdiv_stall_controller_pkg.sv
// Shared ISA constants, FSM encoding and field-extraction helpers for the mult/div stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_stall_controller_pkg;

    // Primary opcodes, instr[31:27]
    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // R-type ALU_op, instr[6:2]
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [4:0]  REG_RSTATUS = 5'd30;
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_WAIT = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic [4:0] f_opcode(input logic [31:0] instr);
        return instr[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[26:22];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] instr);
        return instr[21:17];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[16:12];
    endfunction

    function automatic logic [4:0] f_alu_op(input logic [31:0] instr);
        return instr[6:2];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in DX whose destination is read by the instruction in FD (bypass cannot cover it).
// Latency: combinational.
// Backpressure: none; the caller decides whether the hazard is acted on.
module load_use_detect
    import multdiv_stall_controller_pkg::*;
(
    input  logic [31:0] fd_instr,
    input  logic [31:0] dx_instr,
    output logic        hazard
);

    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       use_a;
    logic       use_b;
    logic [4:0] dx_rd;
    logic       dx_is_lw;
    logic       unused_bits;

    assign dx_rd       = f_rd(dx_instr);
    assign dx_is_lw    = (f_opcode(dx_instr) == OP_LW) && (dx_rd != 5'd0);
    assign unused_bits = ^{fd_instr[11:0], dx_instr[21:0]};

    // Work out which registers the FD instruction actually reads
    always_comb begin
        src_a = f_rs(fd_instr);
        src_b = f_rt(fd_instr);
        use_a = 1'b0;
        use_b = 1'b0;
        case (f_opcode(fd_instr))
            OP_ALU: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                use_a = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a = f_rd(fd_instr);
                src_b = f_rs(fd_instr);
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OP_JR: begin
                src_a = f_rd(fd_instr);
                use_a = 1'b1;
            end
            OP_BEX: begin
                src_a = REG_RSTATUS;
                use_a = 1'b1;
            end
            default: begin
                use_a = 1'b0;
                use_b = 1'b0;
            end
        endcase
    end

    assign hazard = dx_is_lw && ((use_a && (src_a == dx_rd)) || (use_b && (src_b == dx_rd)));

endmodule

// File: rtl/multdiv_stall_controller.sv
// Sequences the shared mult/div unit and owns all pipeline stalls, including load-use bubbles.
// Latency: DX decode to XM capture is N+2 cycles (N = cycles until md_ready), capped by MD_TIMEOUT.
// Backpressure: freezes PC/FD/DX and bubbles XM while the unit is busy; one-cycle bubble on load-use.
module multdiv_stall_controller
    import multdiv_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FD_Latch_Instr,
    input  logic [31:0] DX_Latch_Instr,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall_PC_FD,
    output logic        stall_DX,
    output logic        DX_nop_insert,
    output logic        XM_nop_insert,
    output logic        md_xm_select,
    output logic [31:0] md_xm_data,
    output logic        md_xm_error,
    output logic        md_busy
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_div, op_div_nxt;
    logic [31:0]      res_q, res_nxt;
    logic             err_q, err_nxt;

    logic dx_mul;
    logic dx_div;
    logic load_use;
    logic unused_bits;

    assign dx_mul = (f_opcode(DX_Latch_Instr) == OP_ALU) && (f_alu_op(DX_Latch_Instr) == ALU_MUL);
    assign dx_div = (f_opcode(DX_Latch_Instr) == OP_ALU) && (f_alu_op(DX_Latch_Instr) == ALU_DIV);
    assign unused_bits = ^{DX_Latch_Instr[26:7], DX_Latch_Instr[1:0]};

    load_use_detect u_load_use_detect (
        .fd_instr (FD_Latch_Instr),
        .dx_instr (DX_Latch_Instr),
        .hazard   (load_use)
    );

    // State, timeout counter and captured result/error
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_div <= op_div_nxt;
            res_q  <= res_nxt;
            err_q  <= err_nxt;
        end
    end

    // Next-state and outputs; everything is held low while reset is asserted
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_div_nxt    = op_div;
        res_nxt       = res_q;
        err_nxt       = err_q;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        stall_PC_FD   = 1'b0;
        stall_DX      = 1'b0;
        DX_nop_insert = 1'b0;
        XM_nop_insert = 1'b0;
        md_xm_select  = 1'b0;
        md_xm_data    = 32'd0;
        md_xm_error   = 1'b0;
        md_busy       = 1'b0;
        if (!reset) begin
            md_busy = (state != MD_IDLE);
            case (state)
                MD_IDLE: begin
                    if (dx_mul || dx_div) begin
                        ctrl_MULT     = dx_mul;
                        ctrl_DIV      = dx_div;
                        stall_PC_FD   = 1'b1;
                        stall_DX      = 1'b1;
                        XM_nop_insert = 1'b1;
                        op_div_nxt    = dx_div;
                        cnt_nxt       = '0;
                        err_nxt       = 1'b0;
                        state_nxt     = MD_WAIT;
                    end else if (load_use) begin
                        // DX loads a bubble while FD/PC hold; the load moves on to XM
                        stall_PC_FD   = 1'b1;
                        DX_nop_insert = 1'b1;
                    end
                end
                MD_WAIT: begin
                    stall_PC_FD   = 1'b1;
                    stall_DX      = 1'b1;
                    XM_nop_insert = 1'b1;
                    cnt_nxt       = cnt + CNT_W'(1);
                    if (md_ready) begin
                        res_nxt   = md_result;
                        err_nxt   = md_exception;
                        state_nxt = MD_DONE;
                    end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = MD_DONE;
                    end
                end
                MD_DONE: begin
                    // Stalls drop so the mul/div advances into XM carrying the substituted result
                    md_xm_select = 1'b1;
                    md_xm_error  = err_q;
                    md_xm_data   = err_q ? (op_div ? RSTATUS_DIV : RSTATUS_MUL) : res_q;
                    state_nxt    = MD_IDLE;
                end
                default: begin
                    state_nxt = MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// Directed bench: load-use vector table plus hand-written mul/div, timeout and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_multdiv_stall_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] FD_Latch_Instr;
    logic [31:0] DX_Latch_Instr;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall_PC_FD;
    logic        stall_DX;
    logic        DX_nop_insert;
    logic        XM_nop_insert;
    logic        md_xm_select;
    logic [31:0] md_xm_data;
    logic        md_xm_error;
    logic        md_busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    multdiv_stall_controller #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .FD_Latch_Instr (FD_Latch_Instr),
        .DX_Latch_Instr (DX_Latch_Instr),
        .md_ready       (md_ready),
        .md_exception   (md_exception),
        .md_result      (md_result),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall_PC_FD    (stall_PC_FD),
        .stall_DX       (stall_DX),
        .DX_nop_insert  (DX_nop_insert),
        .XM_nop_insert  (XM_nop_insert),
        .md_xm_select   (md_xm_select),
        .md_xm_data     (md_xm_data),
        .md_xm_error    (md_xm_error),
        .md_busy        (md_busy)
    );

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        string       name;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        stall;
        logic        dnop;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] r_ins(input logic [4:0] alu, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive new inputs just after the rising edge, then wait for the falling edge to sample
    task automatic tick(input logic [31:0] fd, input logic [31:0] dx);
        @(posedge clock);
        #1;
        FD_Latch_Instr = fd;
        DX_Latch_Instr = dx;
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"},
            {31'd0, ctrl_MULT | ctrl_DIV | stall_PC_FD | stall_DX | DX_nop_insert |
                    XM_nop_insert | md_xm_select | md_xm_error | md_busy}, 32'd0);
        chk({tag, " data"}, md_xm_data, 32'd0);
    endtask

    task automatic run_md(input string tag, input logic [31:0] instr, input logic is_div,
                          input int ready_at, input logic exc, input logic [31:0] res,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_stalls);
        int  stalls;
        int  pulses;
        int  sel_early;
        bit  done;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        tick(NOP, instr);
        chk({tag, " launch MULT"}, {31'd0, ctrl_MULT}, {31'd0, ~is_div});
        chk({tag, " launch DIV"},  {31'd0, ctrl_DIV},  {31'd0, is_div});
        chk({tag, " launch XM_nop"}, {31'd0, XM_nop_insert}, 32'd1);
        stalls    = stall_PC_FD ? 1 : 0;
        pulses    = int'(ctrl_MULT) + int'(ctrl_DIV);
        sel_early = 0;
        done      = 1'b0;
        for (int k = 1; k <= 80 && !done; k++) begin
            @(posedge clock);
            #1;
            md_ready     = (k == ready_at);
            md_exception = exc;
            md_result    = res;
            @(negedge clock);
            if (stall_PC_FD) begin
                stalls++;
                pulses    += int'(ctrl_MULT) + int'(ctrl_DIV);
                sel_early += int'(md_xm_select);
            end else begin
                done = 1'b1;
                chk({tag, " done select"}, {31'd0, md_xm_select}, 32'd1);
                chk({tag, " done data"}, md_xm_data, exp_data);
                chk({tag, " done error"}, {31'd0, md_xm_error}, {31'd0, exp_err});
                chk({tag, " done XM_nop/stall_DX"}, {30'd0, XM_nop_insert, stall_DX}, 32'd0);
            end
        end
        md_ready = 1'b0;
        chk({tag, " completed"}, {31'd0, done}, 32'd1);
        chk({tag, " stall cycles"}, stalls, exp_stalls);
        chk({tag, " ctrl pulses"}, pulses, 32'd1);
        chk({tag, " select while stalled"}, sel_early, 32'd0);
    endtask

    initial begin
        // add r6,r5,r7 etc.; opcodes: lw 01000, addi 00101, sw 00111, bne 00010, jr 00100, bex 10110, j 00001
        vecs[0]  = '{"lu rs hit",     r_ins(5'd0, 5'd6, 5'd5, 5'd7), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[1]  = '{"lu lw r0",      r_ins(5'd0, 5'd6, 5'd0, 5'd7), i_ins(5'b01000, 5'd0, 5'd1, 17'd0), 1'b0, 1'b0};
        vecs[2]  = '{"lu rt hit",     r_ins(5'd0, 5'd6, 5'd7, 5'd5), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[3]  = '{"lu addi rs",    i_ins(5'b00101, 5'd6, 5'd5, 17'd1), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[4]  = '{"lu addi rd",    i_ins(5'b00101, 5'd5, 5'd6, 17'd1), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b0, 1'b0};
        vecs[5]  = '{"lu sw rd",      i_ins(5'b00111, 5'd5, 5'd6, 17'd0), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[6]  = '{"lu bne rd",     i_ins(5'b00010, 5'd5, 5'd6, 17'd2), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[7]  = '{"lu jr rd",      i_ins(5'b00100, 5'd5, 5'd0, 17'd0), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[8]  = '{"lu bex r30",    i_ins(5'b10110, 5'd0, 5'd0, 17'd9), i_ins(5'b01000, 5'd30, 5'd1, 17'd0), 1'b1, 1'b1};
        vecs[9]  = '{"lu bex r29",    i_ins(5'b10110, 5'd0, 5'd0, 17'd9), i_ins(5'b01000, 5'd29, 5'd1, 17'd0), 1'b0, 1'b0};
        vecs[10] = '{"lu j no read",  i_ins(5'b00001, 5'd5, 5'd5, 17'd0), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b0, 1'b0};
        vecs[11] = '{"lu dx not lw",  r_ins(5'd0, 5'd6, 5'd5, 5'd7), r_ins(5'd0, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0};
        vecs[12] = '{"lu lw rs",      i_ins(5'b01000, 5'd6, 5'd5, 17'd0), i_ins(5'b01000, 5'd5, 5'd1, 17'd0), 1'b1, 1'b1};

        reset          = 1'b1;
        FD_Latch_Instr = NOP;
        DX_Latch_Instr = r_ins(5'b00110, 5'd3, 5'd1, 5'd2);
        md_ready       = 1'b0;
        md_exception   = 1'b0;
        md_result      = 32'd0;

        // Reset holds everything low even with a mul sitting in DX
        tick(NOP, r_ins(5'b00110, 5'd3, 5'd1, 5'd2));
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset          = 1'b0;
        DX_Latch_Instr = NOP;
        @(negedge clock);
        chk_all_zero("post-reset idle");

        foreach (vecs[i]) begin
            tick(vecs[i].fd, vecs[i].dx);
            chk({vecs[i].name, " stall_PC_FD"}, {31'd0, stall_PC_FD}, {31'd0, vecs[i].stall});
            chk({vecs[i].name, " DX_nop"}, {31'd0, DX_nop_insert}, {31'd0, vecs[i].dnop});
            chk({vecs[i].name, " stall_DX/XM_nop/busy"}, {29'd0, stall_DX, XM_nop_insert, md_busy}, 32'd0);
        end

        // Load-use bubble lasts one cycle: DX becomes a nop, FD still holds the add
        tick(r_ins(5'd0, 5'd6, 5'd5, 5'd7), i_ins(5'b01000, 5'd5, 5'd1, 17'd0));
        chk("lu seq cycle0 stall", {31'd0, stall_PC_FD}, 32'd1);
        tick(r_ins(5'd0, 5'd6, 5'd5, 5'd7), NOP);
        chk("lu seq cycle1 stall", {30'd0, stall_PC_FD, DX_nop_insert}, 32'd0);

        // mul r3,r1,r2, result after 32 cycles: 33 stalled cycles
        run_md("mul32", r_ins(5'b00110, 5'd3, 5'd1, 5'd2), 1'b0, 32, 1'b0, 32'd42, 32'd42, 1'b0, 33);
        tick(NOP, NOP);
        chk("mul32 back idle", {30'd0, md_busy, md_xm_select}, 32'd0);

        // div with exception: rstatus 5
        run_md("divexc", r_ins(5'b00111, 5'd4, 5'd1, 5'd0), 1'b1, 5, 1'b1, 32'h1234, 32'd5, 1'b1, 6);
        tick(NOP, NOP);
        chk("divexc back idle", {30'd0, md_busy, md_xm_select}, 32'd0);

        // No md_ready: forced completion after 40 WAIT cycles, rstatus 4 for mul
        run_md("timeout", r_ins(5'b00110, 5'd3, 5'd1, 5'd2), 1'b0, 0, 1'b0, 32'd0, 32'd4, 1'b1, 41);

        // mul then div back to back, no idle gap; mul into r0 is sequenced normally
        run_md("b2b mul", r_ins(5'b00110, 5'd0, 5'd1, 5'd2), 1'b0, 3, 1'b0, 32'hCAFE, 32'hCAFE, 1'b0, 4);
        run_md("b2b div", r_ins(5'b00111, 5'd7, 5'd1, 5'd2), 1'b1, 4, 1'b0, 32'd7, 32'd7, 1'b0, 5);
        tick(NOP, NOP);

        // Reset in WAIT cycle 10 abandons the operation
        tick(NOP, r_ins(5'b00110, 5'd3, 5'd1, 5'd2));
        chk("rst-mid launch", {31'd0, ctrl_MULT}, 32'd1);
        for (int k = 1; k <= 10; k++) tick(NOP, r_ins(5'b00110, 5'd3, 5'd1, 5'd2));
        chk("rst-mid busy before", {31'd0, md_busy}, 32'd1);
        @(posedge clock);
        #1;
        reset          = 1'b1;
        DX_Latch_Instr = NOP;
        @(negedge clock);
        chk_all_zero("rst-mid during reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk_all_zero("rst-mid after reset");
        @(posedge clock);
        #1;
        md_ready  = 1'b1;
        md_result = 32'd99;
        @(negedge clock);
        chk("rst-mid late ready select", {30'd0, md_xm_select, md_busy}, 32'd0);
        @(posedge clock);
        #1;
        md_ready = 1'b0;
        @(negedge clock);
        chk("rst-mid after ready select", {30'd0, md_xm_select, md_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
